// File: rtl/sync_counter.sv
// rtl/sync_counter.sv - parameterised binary up-counter with clear, load, enable, terminal count and wrap pulse
module sync_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
            $error("sync_counter: illegal WIDTH/MAX_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_val;

    // Out-of-range load values saturate so q never leaves 0..MAX_VAL.
    assign w_load_val = (d > L_MAX) ? L_MAX : d;

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (clear) begin
            w_q_next = '0;
        end else if (load) begin
            w_q_next = w_load_val;
        end else if (en) begin
            if (r_q == L_MAX) begin
                w_q_next    = '0;
                w_wrap_next = 1'b1;
            end else begin
                w_q_next = r_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign tc   = (r_q == L_MAX);

`ifndef SYNTHESIS
    a_wrap_lands_on_zero : assert property (@(posedge clk) disable iff (!reset)
        wrap |-> (q == '0));

    // A single-state counter (MAX_VAL == 0) legitimately wraps every cycle.
    a_wrap_single_cycle : assert property (@(posedge clk) disable iff (!reset)
        (wrap && (L_MAX != '0)) |=> !wrap);

    a_clear_wins : assert property (@(posedge clk) disable iff (!reset)
        clear |=> ((q == '0) && !wrap));

    a_load_over_en : assert property (@(posedge clk) disable iff (!reset)
        (!clear && load) |=> ((q == (($past(d) > L_MAX) ? L_MAX : $past(d))) && !wrap));

    a_increment : assert property (@(posedge clk) disable iff (!reset)
        (!clear && !load && en && (q != L_MAX)) |=> ((q == $past(q) + WIDTH'(1)) && !wrap));

    a_hold : assert property (@(posedge clk) disable iff (!reset)
        (!clear && !load && !en) |=> ((q == $past(q)) && !wrap));
`endif

endmodule

// File: tb/tb_sync_counter.sv
// tb/tb_sync_counter.sv - scoreboard bench for sync_counter (default and MAX_VAL=9 variants)
module tb_sync_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, clear, load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap;
    logic       v_en, v_clear, v_load;
    logic [3:0] v_d;
    logic [3:0] v_q;
    logic       v_tc, v_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sync_counter u_dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (clear),
        .load  (load),
        .d     (d),
        .q     (q),
        .tc    (tc),
        .wrap  (wrap)
    );

    sync_counter #(.WIDTH(4), .MAX_VAL(9)) u_var (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .clear (v_clear),
        .load  (v_load),
        .d     (v_d),
        .q     (v_q),
        .tc    (v_tc),
        .wrap  (v_wrap)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus on the selected counter, queue its expected result,
    // then compare once the edge has produced the output.
    task automatic cyc(input bit sel, input logic e, input logic c, input logic l,
                       input logic [3:0] dv, input logic [3:0] eq, input logic ew,
                       input string tag);
        exp_t x;
        if (!sel) begin
            en = e; clear = c; load = l; d = dv;
        end else begin
            v_en = e; v_clear = c; v_load = l; v_d = dv;
        end
        x.sel  = sel;
        x.q    = eq;
        x.wrap = ew;
        x.tc   = (eq == (sel ? 4'd9 : 4'd15));
        x.tag  = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (!x.sel) begin
            chk({x.tag, "_q"},    q,    x.q);
            chk({x.tag, "_wrap"}, wrap, x.wrap);
            chk({x.tag, "_tc"},   tc,   x.tc);
        end else begin
            chk({x.tag, "_q"},    v_q,    x.q);
            chk({x.tag, "_wrap"}, v_wrap, x.wrap);
            chk({x.tag, "_tc"},   v_tc,   x.tc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b1; clear = 1'b0; load = 1'b0; d = 4'd0;
        v_en = 1'b0; v_clear = 1'b0; v_load = 1'b0; v_d = 4'd0;

        #3;
        chk("rst_early_q", q, 4'd0);
        chk("rst_early_wrap", wrap, 1'b0);
        chk("rst_early_tc", tc, 1'b0);
        #5;
        chk("rst_hold_q", q, 4'd0);
        chk("rst_hold_wrap", wrap, 1'b0);
        #4;
        reset = 1'b1;

        for (int i = 1; i <= 15; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, $sformatf("free%0d", i));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "free_wrap");
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, $sformatf("after_wrap%0d", i));

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, "en_on1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, "en_off1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, "en_off2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, "en_on2");

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  4'd9,  1'b0, "load9");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  4'd0,  1'b0, "clr_over_ld");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 4'd14, 1'b0, "ld_over_en");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 1'b0, "tc15");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, "wrap2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, "wrap_drop");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0, "load15");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 1'b0, "hold15");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, "clear");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd10, 1'b0, "load10");

        en = 1'b1; load = 1'b1; d = 4'd7;
        #3;
        reset = 1'b0;
        #1;
        chk("async_q", q, 4'd0);
        chk("async_wrap", wrap, 1'b0);
        chk("async_tc", tc, 1'b0);
        @(posedge clk);
        #1;
        chk("async_held_q", q, 4'd0);
        chk("async_held_vq", v_q, 4'd0);
        #3;
        load = 1'b0;
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "async_rel1");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "async_rel2");

        en = 1'b0;
        for (int i = 1; i <= 9; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, $sformatf("v_run%0d", i));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "v_wrap1");
        for (int i = 1; i <= 9; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, $sformatf("v_rerun%0d", i));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, "v_wrap2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd1, 1'b0, "v_post");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0, "v_sat12");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd9, 1'b0, "v_sat15");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, "v_wrap3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
